// File: rtl/custcop_axi_lite_slave_if.sv
// AXI4-Lite bus bundle for the custom coprocessor register slave.
// Carries AW, W, B, AR and R channels; master/slave modports set direction.
interface custcop_axi_lite_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/custcop_axi_lite_slave.sv
// AXI4-Lite slave with four 32-bit coprocessor registers (S00_AXI endpoint).
// Ports: s00_axi_aclk, s00_axi_aresetn (async, active-low), s00_axi (bus
// interface, slave modport), cop_reg0..cop_reg3 (live register contents).
// Optional macro CUSTCOP_AXI_ADDR_CHECK_EN: addresses with bits above 3 or
// addr[1:0] set get SLVERR; writes dropped, reads return 0.
module custcop_axi_lite_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    custcop_axi_lite_slave_if.slave s00_axi,
    output logic [31:0]             cop_reg0,
    output logic [31:0]             cop_reg1,
    output logic [31:0]             cop_reg2,
    output logic [31:0]             cop_reg3
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ACCEPT,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    w_state_t    w_state;
    w_state_t    w_next;
    r_state_t    r_state;
    r_state_t    r_next;

    logic [31:0] regs [4];
    logic [1:0]  bresp_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        arready_q;
    logic        arready_d;

    logic        w_fire;
    logic        ar_fire;
    logic        w_err;
    logic        r_err;
    logic [1:0]  w_idx;
    logic [1:0]  r_idx;
    logic        unused_ok;

    assign w_idx = s00_axi.awaddr[3:2];
    assign r_idx = s00_axi.araddr[3:2];

`ifdef CUSTCOP_AXI_ADDR_CHECK_EN
    // Only addr[3:2] may be nonzero for a legal word-aligned register access.
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] OK_MASK =
        C_S_AXI_ADDR_WIDTH'(12);
    assign w_err = |(s00_axi.awaddr & ~OK_MASK);
    assign r_err = |(s00_axi.araddr & ~OK_MASK);
`else
    assign w_err = 1'b0;
    assign r_err = 1'b0;
`endif

    assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot,
                         s00_axi.awaddr, s00_axi.araddr};

    // ---------------- write path ----------------
    // Both ready strobes come straight from the ACCEPT state, so they are
    // registered and rise together one cycle after both valids are seen.
    assign s00_axi.awready = (w_state == W_ACCEPT);
    assign s00_axi.wready  = (w_state == W_ACCEPT);
    assign s00_axi.bvalid  = (w_state == W_RESP);
    assign s00_axi.bresp   = bresp_q;

    assign w_fire = (w_state == W_ACCEPT) &&
                    s00_axi.awvalid && s00_axi.wvalid;

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE: begin
                if (s00_axi.awvalid && s00_axi.wvalid && !s00_axi.bvalid)
                    w_next = W_ACCEPT;
            end
            W_ACCEPT: w_next = W_RESP;
            W_RESP: begin
                if (s00_axi.bready)
                    w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            w_state <= W_IDLE;
            bresp_q <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            if (w_state == W_ACCEPT)
                bresp_q <= w_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int i = 0; i < 4; i++)
                regs[i] <= '0;
        end else if (w_fire && !w_err) begin
            for (int k = 0; k < 4; k++)
                if (s00_axi.wstrb[k])
                    regs[w_idx][8*k +: 8] <= s00_axi.wdata[8*k +: 8];
        end
    end

    // ---------------- read path ----------------
    // arready is a one-cycle pulse; the handshake edge captures the
    // pre-write register value, so a same-edge write reads back old data.
    assign s00_axi.arready = arready_q;
    assign s00_axi.rvalid  = (r_state == R_DATA);
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = rresp_q;

    assign ar_fire = arready_q && s00_axi.arvalid;

    always_comb begin
        r_next    = r_state;
        arready_d = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                arready_d = s00_axi.arvalid && !arready_q;
                if (ar_fire)
                    r_next = R_DATA;
            end
            R_DATA: begin
                if (s00_axi.rready)
                    r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state   <= r_next;
            arready_q <= arready_d;
            if (ar_fire) begin
                rdata_q <= r_err ? 32'h0 : regs[r_idx];
                rresp_q <= r_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign cop_reg0 = regs[0];
    assign cop_reg1 = regs[1];
    assign cop_reg2 = regs[2];
    assign cop_reg3 = regs[3];
endmodule

// File: tb/tb_custcop_axi_lite_slave.sv
// Scoreboard bench for custcop_axi_lite_slave (6-bit address bus).
// Expected B/R responses are queued at issue and checked by a monitor.
module tb_custcop_axi_lite_slave;
    localparam int AW = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cop0;
    logic [31:0] cop1;
    logic [31:0] cop2;
    logic [31:0] cop3;

    always #5 clk = ~clk;

    custcop_axi_lite_slave_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

    custcop_axi_lite_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW)
    ) u_dut (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(rst_n),
        .s00_axi        (bus),
        .cop_reg0       (cop0),
        .cop_reg1       (cop1),
        .cop_reg2       (cop2),
        .cop_reg3       (cop3)
    );

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
    } rexp_t;

    int    checks = 0;
    int    errors = 0;
    logic [1:0] exp_b_q [$];
    rexp_t      exp_r_q [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        rexp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.bvalid && bus.bready) begin
                if (exp_b_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: bresp %b", bus.bresp);
                end else begin
                    chk("bresp", {30'b0, bus.bresp}, {30'b0, exp_b_q.pop_front()});
                end
            end
            if (rst_n && bus.rvalid && bus.rready) begin
                if (exp_r_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_unexpected: rdata %h", bus.rdata);
                end else begin
                    e = exp_r_q.pop_front();
                    chk("rdata", bus.rdata, e.d);
                    chk("rresp", {30'b0, bus.rresp}, {30'b0, e.r});
                end
            end
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int skew,
                      input logic [1:0] er);
        int n;
        exp_b_q.push_back(er);
        bus.awaddr  = a;
        bus.wdata   = d;
        bus.wstrb   = s;
        bus.awvalid = 1'b1;
        for (int i = 0; i < skew; i++) begin
            @(negedge clk);
            chk("aw_alone_ready", {30'b0, bus.awready, bus.wready}, 32'h0);
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.awready && n < 50);
        if (!bus.awready) begin
            checks++; errors++;
            $display("FAIL aw_timeout: awready 0 after %0d cycles", n);
        end
        chk("wready_with_awready", {31'b0, bus.wready}, 32'h1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    task automatic wait_b(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.bvalid && bus.bready) && n < 50);
        if (!(bus.bvalid && bus.bready)) begin
            checks++; errors++;
            $display("FAIL b_timeout: no B handshake in %0d cycles", n);
        end
        @(posedge clk); #1;
    endtask

    task automatic rd_issue(input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [1:0] r, output int n);
        rexp_t e;
        e.d = d;
        e.r = r;
        exp_r_q.push_back(e);
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.arready && n < 50);
        if (!bus.arready) begin
            checks++; errors++;
            $display("FAIL ar_timeout: arready 0 after %0d cycles", n);
        end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic wait_r(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.rvalid && bus.rready) && n < 50);
        if (!(bus.rvalid && bus.rready)) begin
            checks++; errors++;
            $display("FAIL r_timeout: no R handshake in %0d cycles", n);
        end
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [1:0] r);
        int n;
        rd_issue(a, d, r, n);
        wait_r(n);
    endtask

    initial begin
        int n;
        int m;
        bus.awaddr  = '0;
        bus.awprot  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        bus.araddr  = '0;
        bus.arprot  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;

        fork
            monitor();
        join_none

        // reset
        #100;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ctrl", {27'b0, bus.awready, bus.wready, bus.bvalid,
                         bus.arready, bus.rvalid}, 32'h0);
        chk("rst_resp", {28'b0, bus.bresp, bus.rresp}, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_cop", cop0 | cop1 | cop2 | cop3, 32'h0);
        @(posedge clk); #1;

        // basic writes and readback
        wr(6'h0, 32'h1, 4'hF, 0, 2'b00);
        wait_b(n);
        chk("b_latency", n, 32'd1);
        wr(6'h4, 32'h2, 4'hF, 0, 2'b00);
        wait_b(n);
        wr(6'h8, 32'h3, 4'hF, 0, 2'b00);
        wait_b(n);
        wr(6'hC, 32'h4, 4'hF, 0, 2'b00);
        wait_b(n);
        chk("cop0", cop0, 32'h1);
        chk("cop1", cop1, 32'h2);
        chk("cop2", cop2, 32'h3);
        chk("cop3", cop3, 32'h4);

        rd_issue(6'h0, 32'h1, 2'b00, n);
        chk("ar_latency", n, 32'd2);
        wait_r(m);
        chk("r_latency", m, 32'd1);
        rd(6'h4, 32'h2, 2'b00);
        rd(6'h8, 32'h3, 2'b00);
        rd(6'hC, 32'h4, 2'b00);

        // byte strobes over 0x00000002
        wr(6'h4, 32'hAABBCCDD, 4'b0101, 0, 2'b00);
        wait_b(n);
        chk("strb_cop1", cop1, 32'h00BB00DD);
        rd(6'h4, 32'h00BB00DD, 2'b00);

        // stalled write response, second write held off
        bus.bready = 1'b0;
        wr(6'h8, 32'h55, 4'hF, 0, 2'b00);
        bus.awaddr  = 6'hC;
        bus.wdata   = 32'h66;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bstall_bvalid", {31'b0, bus.bvalid}, 32'h1);
            chk("bstall_awready", {31'b0, bus.awready}, 32'h0);
            @(posedge clk); #1;
        end
        bus.bready = 1'b1;
        wr(6'hC, 32'h66, 4'hF, 0, 2'b00);
        wait_b(n);
        chk("bstall_cop2", cop2, 32'h55);
        chk("bstall_cop3", cop3, 32'h66);

        // stalled read data, held stable
        bus.rready = 1'b0;
        rd_issue(6'h8, 32'h55, 2'b00, n);
        bus.araddr  = 6'hC;
        bus.arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstall_rvalid", {31'b0, bus.rvalid}, 32'h1);
            chk("rstall_rdata", bus.rdata, 32'h55);
            chk("rstall_arready", {31'b0, bus.arready}, 32'h0);
            @(posedge clk); #1;
        end
        bus.rready = 1'b1;
        rd(6'hC, 32'h66, 2'b00);

        // AW three cycles ahead of W
        wr(6'h0, 32'h12345678, 4'hF, 3, 2'b00);
        wait_b(n);
        chk("skew_cop0", cop0, 32'h12345678);
        rd(6'h0, 32'h12345678, 2'b00);

        // same-edge read of a register being written returns old data
        fork
            begin
                int nb;
                wr(6'h4, 32'h77, 4'hF, 0, 2'b00);
                wait_b(nb);
            end
            begin
                int na;
                int nr;
                rd_issue(6'h4, 32'h00BB00DD, 2'b00, na);
                wait_r(nr);
            end
        join
        rd(6'h4, 32'h77, 2'b00);

        // out-of-range / misaligned addresses
`ifdef CUSTCOP_AXI_ADDR_CHECK_EN
        wr(6'h10, 32'hFFFF, 4'hF, 0, 2'b10);
        wait_b(n);
        chk("addr_cop0", cop0, 32'h12345678);
        rd(6'h10, 32'h0, 2'b10);
        rd(6'h05, 32'h0, 2'b10);
`else
        wr(6'h10, 32'hFFFF, 4'hF, 0, 2'b00);
        wait_b(n);
        chk("addr_cop0", cop0, 32'h0000FFFF);
        rd(6'h10, 32'h0000FFFF, 2'b00);
        rd(6'h05, 32'h77, 2'b00);
`endif

        repeat (3) @(posedge clk);
        chk("b_queue_drained", exp_b_q.size(), 32'd0);
        chk("r_queue_drained", exp_r_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
